kbd_fifo: RTL and testbench

Keystroke buffer between the PS/2 keyboard decoder and the CPU-facing TTY bus port. Each one-cycle-or-longer `key_valid` event pushes the decoded ASCII byte into a DEPTH-entry FIFO. A CPU read pops the oldest byte, so bursts of typing are not lost while the CPU is busy. Status flags drive the TTY `keypress` line and a sticky overflow indicator.

---
 rtl/kbd_fifo.sv | 127 ++++++++++++
 tb/tb_kbd_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/kbd_fifo.sv
// kbd_fifo: keystroke buffer between the PS/2 decoder and the CPU TTY port.
// Rising edges of key_valid push key_ascii; rising edges of read pop the
// oldest byte into the registered rd_data. Status flags come from count.
//
// Strobe semantics: key_valid and read are levels of any length. Only their
// rising edge (current high, previous-cycle low) performs an operation, so a
// strobe held high for N cycles acts once. There is no ready/backpressure:
// a push into a full FIFO with no same-cycle pop is dropped and latches the
// sticky overflow flag, and a pop on an empty FIFO returns 8'h00 harmlessly.
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_50mhz,
    input  logic          rst,
    input  logic [7:0]    key_ascii,
    input  logic          key_valid,
    input  logic          read,
    input  logic          ovf_clr,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          keypress
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          kv_q;
    logic          rd_q;

    logic push_req;
    logic pop_req;
    logic do_pop;
    logic do_push;
    logic drop;

    // Edge detection and push/pop qualification; a pop frees a slot for a
    // same-cycle push, so a full FIFO can still accept when read coincides.
    always_comb begin
        push_req = key_valid & ~kv_q;
        pop_req  = read & ~rd_q;
        do_pop   = pop_req & ~empty;
        do_push  = push_req & (~full | do_pop);
        drop     = push_req & full & ~do_pop;
    end

    // Status flags derived from the registered occupancy counter.
    always_comb begin
        empty    = (count == '0);
        full     = (count == FULL_CNT);
        keypress = ~empty;
    end

    // Previous-cycle strobe levels; cleared by reset so a strobe held across
    // reset release is seen as a fresh edge.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            kv_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            kv_q <= key_valid;
            rd_q <= read;
        end
    end

    // Storage array; contents are not reset, pointers define validity.
    always_ff @(posedge clk_50mhz) begin
        if (do_push) begin
            mem[wp] <= key_ascii;
        end
    end

    // Pointers wrap by natural overflow of their AW-bit width.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

    // Occupancy counter: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read data register: loads the head on a pop, 8'h00 on an empty pop,
    // otherwise holds so the bus can sample it on a later cycle.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (pop_req) begin
            rd_data <= do_pop ? mem[rp] : 8'h00;
        end
    end

    // Sticky overflow; a dropped push wins over a same-cycle clear.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kbd_fifo.sv
// tb_kbd_fifo: directed bench for kbd_fifo with a byte scoreboard queue.
module tb_kbd_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk_50mhz;
    logic          rst;
    logic [7:0]    key_ascii;
    logic          key_valid;
    logic          read;
    logic          ovf_clr;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          keypress;

    logic [7:0] exp_q[$];
    int         m_count;
    int         vectors;
    int         errs;

    kbd_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .key_ascii (key_ascii),
        .key_valid (key_valid),
        .read      (read),
        .ovf_clr   (ovf_clr),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .keypress  (keypress)
    );

    // Clock generation: 50 MHz.
    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_status();
        check("count", 32'(count), 32'(m_count));
        check("empty", 32'(empty), 32'(m_count == 0));
        check("full", 32'(full), 32'(m_count == DEPTH));
        check("keypress", 32'(keypress), 32'(m_count != 0));
    endtask

    // One push strobe (high one cycle, then low one cycle).
    task automatic push(input logic [7:0] d);
        key_ascii = d;
        key_valid = 1'b1;
        step();
        if (m_count < DEPTH) begin
            exp_q.push_back(d);
            m_count++;
        end
        check("push_count", 32'(count), 32'(m_count));
        key_valid = 1'b0;
        step();
    endtask

    // One pop strobe; rd_data checked the cycle after the rising edge.
    task automatic pop();
        logic [7:0] e;
        e = 8'h00;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_count--;
        end
        read = 1'b1;
        step();
        check("pop_data", 32'(rd_data), 32'(e));
        check("pop_count", 32'(count), 32'(m_count));
        read = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] e;
        vectors   = 0;
        errs      = 0;
        m_count   = 0;
        rst       = 1'b1;
        key_ascii = 8'h00;
        key_valid = 1'b0;
        read      = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state.
        #1;
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'h0);
        check_status();
        step();
        step();
        rst = 1'b0;
        step();

        // Single push, then read held for three cycles: exactly one pop.
        push(8'h41);
        check_status();
        e = exp_q.pop_front();
        m_count--;
        read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_read_data", 32'(rd_data), 32'(e));
            check_status();
        end
        read = 1'b0;
        step();

        // Fill to full, overflowing 17th push, drain in order, clear flag.
        for (int i = 0; i < DEPTH; i++) push(8'h30 + 8'(i));
        check_status();
        check("ovf_before", 32'(overflow), 32'h0);
        push(8'h40);
        check("ovf_set", 32'(overflow), 32'h1);
        check_status();
        for (int i = 0; i < DEPTH; i++) pop();
        check_status();
        check("ovf_sticky", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) push(8'h80 + 8'(i));
        for (int i = 0; i < 10; i++) pop();
        for (int i = 0; i < 12; i++) push(8'hA0 + 8'(i));
        for (int i = 0; i < 12; i++) pop();
        check_status();

        // Simultaneous push and pop while full.
        for (int i = 0; i < DEPTH; i++) push(8'h70 + 8'(i));
        check_status();
        e = exp_q.pop_front();
        exp_q.push_back(8'h55);
        key_ascii = 8'h55;
        key_valid = 1'b1;
        read      = 1'b1;
        step();
        check("full_both_data", 32'(rd_data), 32'(e));
        check_status();
        check("full_both_ovf", 32'(overflow), 32'h0);
        key_valid = 1'b0;
        read      = 1'b0;
        step();
        for (int i = 0; i < DEPTH; i++) pop();
        check_status();

        // Read on empty, then simultaneous push and pop on empty.
        pop();
        check_status();
        key_ascii = 8'h61;
        key_valid = 1'b1;
        read      = 1'b1;
        step();
        exp_q.push_back(8'h61);
        m_count = 1;
        check("empty_both_data", 32'(rd_data), 32'h00);
        check_status();
        key_valid = 1'b0;
        read      = 1'b0;
        step();
        pop();

        // Reset mid-stream with key_valid held high.
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        check_status();
        key_ascii = 8'h99;
        key_valid = 1'b1;
        rst       = 1'b1;
        #1;
        exp_q.delete();
        m_count = 0;
        check("midrst_rd_data", 32'(rd_data), 32'h00);
        check("midrst_ovf", 32'(overflow), 32'h0);
        check_status();
        step();
        rst = 1'b0;
        step();
        exp_q.push_back(8'h99);
        m_count = 1;
        check_status();
        step();
        check("held_kv_once", 32'(count), 32'(m_count));
        key_valid = 1'b0;
        step();
        pop();
        check_status();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
